// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweeper: FSM state encoding and
// a constant-friendly clog2 used for register sizing here and in the bench.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } sweep_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-interval counter: cleared on entry to a combination, counts while
// enabled, and flags the last settle cycle.
module sweep_settle_timer
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = clog2(SETTLE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_truth_table_sweeper.sv
// Sweeps every input combination onto a gate under test, captures its output
// into a truth table after a settle interval, and compares to an expected table.
module gate_truth_table_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [(1<<N_INPUTS)-1:0]   exp_table,
  input  logic                       gate_out,
  output logic [N_INPUTS-1:0]        drive_vec,
  output logic                       busy,
  output logic                       done,
  output logic [(1<<N_INPUTS)-1:0]   truth_table,
  output logic                       pass
);

  localparam int unsigned TBL_W = 1 << N_INPUTS;
  // One spare bit so the last index is compared, never reached by wrap.
  localparam int unsigned IDX_W = clog2(TBL_W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_W - 1);

  sweep_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [TBL_W-1:0] exp_reg;
  logic             expired;

  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == DRIVE),
    .en     (state == SETTLE),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      drive_vec   <= '0;
      truth_table <= '0;
      exp_reg     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx         <= '0;
            truth_table <= '0;
            exp_reg     <= exp_table;
            state       <= DRIVE;
          end
        end
        DRIVE: begin
          drive_vec <= idx[N_INPUTS-1:0];
          state     <= SETTLE;
        end
        SETTLE: begin
          if (expired) state <= CAPTURE;
        end
        CAPTURE: begin
          truth_table[idx[N_INPUTS-1:0]] <= gate_out;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == DRIVE) || (state == SETTLE) || (state == CAPTURE);
  assign done = (state == DONE);
  assign pass = done && (truth_table == exp_reg);

endmodule

// File: tb/tb_gate_truth_table_sweeper.sv
// Directed bench: sweeper driving a 2-input OR gate, default settle and a
// short-settle instance.
module tb_gate_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] exp_table;
  logic       gate_out;
  logic [1:0] drive_vec;
  logic       busy;
  logic       done;
  logic [3:0] truth_table;
  logic       pass;

  logic       start1;
  logic [3:0] exp_table1;
  logic       gate_out1;
  logic [1:0] drive_vec1;
  logic       busy1;
  logic       done1;
  logic [3:0] truth_table1;
  logic       pass1;

  int n_checks;
  int n_fail;

  gate_truth_table_sweeper #(.N_INPUTS(2), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_table(exp_table),
    .gate_out(gate_out), .drive_vec(drive_vec), .busy(busy), .done(done),
    .truth_table(truth_table), .pass(pass)
  );

  gate_truth_table_sweeper #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .exp_table(exp_table1),
    .gate_out(gate_out1), .drive_vec(drive_vec1), .busy(busy1), .done(done1),
    .truth_table(truth_table1), .pass(pass1)
  );

  // OR gate under test: a = bit 0, b = bit 1
  assign gate_out  = drive_vec[0] | drive_vec[1];
  assign gate_out1 = drive_vec1[0] | drive_vec1[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for the edge that samples it; returns edges until done (-1 on timeout).
  task automatic sweep_edges(output int edges);
    edges = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (drive_vec !== 2'b00 || truth_table !== 4'b0000 || busy !== 1'b0 ||
        done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: dv=%b tt=%b busy=%b done=%b pass=%b, expected all 0",
               drive_vec, truth_table, busy, done, pass);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_or_pass;
    int edges;
    exp_table = 4'b1110;
    sweep_edges(edges);
    n_checks++;
    if (edges !== 24) begin
      n_fail++;
      $display("FAIL pass_done_edge: got %0d expected 24", edges);
    end
    n_checks++;
    if (truth_table !== 4'b1110 || pass !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_table: tt=%b pass=%b busy=%b expected tt=1110 pass=1 busy=0",
               truth_table, pass, busy);
    end
  endtask

  task automatic test_or_mismatch;
    int edges;
    exp_table = 4'b1000;
    sweep_edges(edges);
    n_checks++;
    if (edges !== 24) begin
      n_fail++;
      $display("FAIL mismatch_done_edge: got %0d expected 24", edges);
    end
    n_checks++;
    if (truth_table !== 4'b1110 || pass !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_table: tt=%b pass=%b done=%b expected tt=1110 pass=0 done=1",
               truth_table, pass, done);
    end
  endtask

  task automatic test_drive_sequence;
    logic [1:0] exp_dv;
    int         seq_fail;
    exp_table = 4'b1110;
    seq_fail  = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      exp_dv = 2'((n - 1) / 6);
      n_checks++;
      if (drive_vec !== exp_dv || busy !== (n < 24) || done !== (n == 24)) begin
        n_fail++;
        seq_fail++;
        if (seq_fail <= 4)
          $display("FAIL drive_seq edge %0d: dv=%b busy=%b done=%b expected dv=%b busy=%b done=%b",
                   n, drive_vec, busy, done, exp_dv, (n < 24), (n == 24));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (drive_vec !== 2'b11 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL drive_hold_done: dv=%b done=%b expected dv=11 done=1", drive_vec, done);
    end
  endtask

  task automatic test_start_ignored;
    int first_done;
    exp_table  = 4'b1110;
    first_done = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start = (n == 9);
      if (done && first_done < 0) first_done = n;
    end
    start = 1'b0;
    n_checks++;
    if (first_done !== 24) begin
      n_fail++;
      $display("FAIL start_ignored_edge: done at %0d expected 24", first_done);
    end
    n_checks++;
    if (truth_table !== 4'b1110 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored_table: tt=%b pass=%b expected 1110 pass=1", truth_table, pass);
    end
  endtask

  task automatic test_mid_reset;
    int edges;
    exp_table = 4'b1110;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    n_checks++;
    if (drive_vec !== 2'b10 || truth_table !== 4'b0010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_before_reset: dv=%b tt=%b busy=%b expected dv=10 tt=0010 busy=1",
               drive_vec, truth_table, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (drive_vec !== 2'b00 || truth_table !== 4'b0000 || busy !== 1'b0 ||
        done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_reset: dv=%b tt=%b busy=%b done=%b pass=%b expected all 0",
               drive_vec, truth_table, busy, done, pass);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sweep_edges(edges);
    n_checks++;
    if (edges !== 24 || truth_table !== 4'b1110 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_restart: edges=%0d tt=%b pass=%b expected 24 1110 1",
               edges, truth_table, pass);
    end
  endtask

  task automatic test_short_settle;
    int first_done;
    exp_table1 = 4'b1110;
    // first sweep from IDLE to reach DONE
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    first_done = -1;
    for (int n = 1; n <= 40 && first_done < 0; n++) begin
      @(posedge clk); #1;
      if (done1) first_done = n;
    end
    n_checks++;
    if (first_done !== 12 || truth_table1 !== 4'b1110) begin
      n_fail++;
      $display("FAIL short_first: done at %0d tt=%b expected 12 1110", first_done, truth_table1);
    end
    // restart from DONE: table must clear on the sampling edge
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n_checks++;
    if (truth_table1 !== 4'b0000 || busy1 !== 1'b1 || done1 !== 1'b0 || pass1 !== 1'b0) begin
      n_fail++;
      $display("FAIL short_clear: tt=%b busy=%b done=%b pass=%b expected 0000 1 0 0",
               truth_table1, busy1, done1, pass1);
    end
    first_done = -1;
    for (int n = 1; n <= 40 && first_done < 0; n++) begin
      @(posedge clk); #1;
      if (done1) first_done = n;
    end
    n_checks++;
    if (first_done !== 12 || truth_table1 !== 4'b1110 || pass1 !== 1'b1) begin
      n_fail++;
      $display("FAIL short_second: done at %0d tt=%b pass=%b expected 12 1110 1",
               first_done, truth_table1, pass1);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    start      = 1'b0;
    start1     = 1'b0;
    exp_table  = 4'b0000;
    exp_table1 = 4'b0000;
    rst_n      = 1'b1;
    #2;
    test_reset;
    test_or_pass;
    test_or_mismatch;
    test_drive_sequence;
    test_start_ignored;
    test_mid_reset;
    test_short_settle;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
